parking_lane_arbiter: RTL
=========================

// Module: parking_lane_arbiter
// PURPOSE
//  Shares one barrier/verification resource between the entrance and exit lanes of the car park.
//  Arbitrates lane requests, sequences the external password checker for entries, and drives both gates.
//  Tracks occupancy against CAPACITY and refuses entry when full.
//  Sits between the lane sensors, the password checker and the gate actuators.
// PARAMETERS
//  CAPACITY      8       max cars inside; entry refused at occupancy==CAPACITY
//  CNT_W         4       occupancy width; must satisfy 2**CNT_W > CAPACITY
//  AUTH_TIMEOUT  10000   cycles allowed for checker verdict in AUTH
//  GATE_HOLD     500     cycles a gate stays open waiting for pass_sensor
//  TIMER_W       16      shared timer width; must hold max(AUTH_TIMEOUT,GATE_HOLD)
// PORTS
//  clock          in   1      single clock, rising edge
//  reset_n        in   1      synchronous, active-low reset
//  entry_req      in   1      level: car waiting at entrance
//  exit_req       in   1      level: car waiting at exit
//  pass_sensor    in   1      pulse: car has cleared the currently open gate
//  auth_ok        in   1      pulse from password checker: password accepted
//  auth_fail      in   1      pulse from password checker: password rejected
//  auth_start     out  1      1-cycle pulse: start password check
//  entrance_gate  out  1      1 = entrance barrier open
//  exit_gate      out  1      1 = exit barrier open
//  occupancy      out  CNT_W  cars currently inside
//  full           out  1      occupancy == CAPACITY
//  busy           out  1      state != IDLE
// BEHAVIOUR
//  Reset (reset_n==0 at posedge): state=IDLE, occupancy=0, timer=0, last_served=ENTRY.
//    All outputs 0 (full=0). Reset mid-operation aborts any cycle and closes both gates next edge.
//  States: IDLE, AUTH, OPEN_IN, OPEN_OUT, COOLDOWN; all outputs registered/decoded from state.
//  entry_ok = entry_req & !full. exit_ok = exit_req & (occupancy!=0); exit at occupancy 0 ignored.
//  IDLE: both ok -> lane opposite last_served wins (round-robin); first contest after reset goes to exit.
//    entry_ok only -> AUTH. exit_ok only -> OPEN_OUT (no auth on exit). last_served updated on grant.
//  AUTH: auth_start=1 in the first AUTH cycle only. Gates closed.
//    auth_fail -> COOLDOWN (fail wins if auth_ok same cycle). auth_ok -> OPEN_IN.
//    No verdict by timer==AUTH_TIMEOUT-1 -> COOLDOWN; auth_ok on that same cycle still wins.
//    entry_req dropping during AUTH is ignored.
//  OPEN_IN: entrance_gate=1. pass_sensor -> occupancy+1, COOLDOWN.
//    timer==GATE_HOLD-1 without pass -> COOLDOWN, no count.
//  OPEN_OUT: exit_gate=1. pass_sensor -> occupancy-1, COOLDOWN. Hold timeout as OPEN_IN, no count.
//  COOLDOWN: exactly 1 cycle, both gates closed -> IDLE. Requests not sampled.
//  Gates never open simultaneously; entrance/exit gate rise 1 edge after the granting transition.
//  Timer cleared on every state change; increments each cycle in AUTH/OPEN_*.
//  Occupancy saturates at 0 and CAPACITY (guards, never wraps); full combinational on occupancy.
//  pass_sensor outside OPEN_* states is ignored.
// STRUCTURE
//  parking_pkg: state encodings (3-bit), LANE_ENTRY/LANE_EXIT constants, default CAPACITY/timeouts.
//  Sub-module parking_timer: clear/enable counter with terminal compare (limit-1) -> expire pulse.
//  Top: FSM + round-robin bit + occupancy counter; no other hierarchy.
// TESTING
//  Entry: entry_req=1, auth_ok 5 cycles after auth_start, pass_sensor 3 cycles later
//    -> entrance_gate high until pass, occupancy 0->1, back to IDLE after 1 COOLDOWN cycle.
//  Contest: occupancy=3, entry_req=exit_req=1 held -> grants exit, entry, exit in order;
//    auth_start only on entry grants.
//  Full: CAPACITY=2, two entries -> full=1; third entry_req ignored (no auth_start).
//    One exit -> full=0 and entry proceeds.
//  Timeouts: AUTH_TIMEOUT=20, no verdict -> COOLDOWN after 20 AUTH cycles;
//    GATE_HOLD=10, no pass -> gate closes after 10 cycles, occupancy unchanged.
//  Verdict edge cases: auth_ok & auth_fail same cycle -> COOLDOWN;
//    auth_ok on final timeout cycle -> OPEN_IN.
//  Reset mid OPEN_IN (reset_n low 1 cycle) -> next edge gates=0, occupancy=0, state IDLE;
//    exit_req with occupancy 0 -> no grant.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared encodings and default sizing for the car-park lane arbiter.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_AUTH     = 3'd1,
        ST_OPEN_IN  = 3'd2,
        ST_OPEN_OUT = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_e;

    localparam logic LANE_ENTRY = 1'b0;
    localparam logic LANE_EXIT  = 1'b1;

    localparam int DEF_CAPACITY     = 8;
    localparam int DEF_CNT_W        = 4;
    localparam int DEF_AUTH_TIMEOUT = 10000;
    localparam int DEF_GATE_HOLD    = 500;
    localparam int DEF_TIMER_W      = 16;

endpackage

// File: rtl/parking_timer.sv
// Clearable up-counter; expire is asserted while enabled on the limit-1 count.
module parking_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] limit,
    output logic               expire
);

    localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q == (limit - ONE));

endmodule

// File: rtl/parking_lane_arbiter.sv
// Shares one barrier/verification resource between entrance and exit lanes,
// sequencing the password checker for entries and tracking occupancy.
module parking_lane_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int AUTH_TIMEOUT = DEF_AUTH_TIMEOUT,
    parameter int GATE_HOLD    = DEF_GATE_HOLD,
    parameter int TIMER_W      = DEF_TIMER_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             pass_sensor,
    input  logic             auth_ok,
    input  logic             auth_fail,
    output logic             auth_start,
    output logic             entrance_gate,
    output logic             exit_gate,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             busy
);

    localparam logic [CNT_W-1:0]   CAP_CNT    = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0]   ONE_CNT    = CNT_W'(1);
    localparam logic [TIMER_W-1:0] AUTH_LIMIT = TIMER_W'(AUTH_TIMEOUT);
    localparam logic [TIMER_W-1:0] HOLD_LIMIT = TIMER_W'(GATE_HOLD);

    state_e           state_q, state_d;
    logic             last_served_q, last_served_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             auth_start_q, auth_start_d;
    logic             entrance_gate_q, entrance_gate_d;
    logic             exit_gate_q, exit_gate_d;
    logic             busy_q, busy_d;

    logic               entry_ok, exit_ok, grant_exit;
    logic               timer_clear, timer_en, timer_expire;
    logic [TIMER_W-1:0] timer_limit;

    assign full       = (occ_q == CAP_CNT);
    assign entry_ok   = entry_req & ~full;
    assign exit_ok    = exit_req & (occ_q != '0);
    // Exit wins a contest unless it was the lane served last.
    assign grant_exit = exit_ok & (~entry_ok | (last_served_q == LANE_ENTRY));

    assign timer_en    = (state_q == ST_AUTH) || (state_q == ST_OPEN_IN) ||
                         (state_q == ST_OPEN_OUT);
    assign timer_limit = (state_q == ST_AUTH) ? AUTH_LIMIT : HOLD_LIMIT;
    assign timer_clear = (state_d != state_q);

    parking_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .limit   (timer_limit),
        .expire  (timer_expire)
    );

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        occ_d         = occ_q;
        unique case (state_q)
            ST_IDLE: begin
                if (entry_ok || exit_ok) begin
                    if (grant_exit) begin
                        state_d       = ST_OPEN_OUT;
                        last_served_d = LANE_EXIT;
                    end else begin
                        state_d       = ST_AUTH;
                        last_served_d = LANE_ENTRY;
                    end
                end
            end
            ST_AUTH: begin
                // A rejection overrides a simultaneous accept; an accept beats the timeout.
                if (auth_fail) begin
                    state_d = ST_COOLDOWN;
                end else if (auth_ok) begin
                    state_d = ST_OPEN_IN;
                end else if (timer_expire) begin
                    state_d = ST_COOLDOWN;
                end
            end
            ST_OPEN_IN: begin
                if (pass_sensor) begin
                    if (occ_q != CAP_CNT) begin
                        occ_d = occ_q + ONE_CNT;
                    end
                    state_d = ST_COOLDOWN;
                end else if (timer_expire) begin
                    state_d = ST_COOLDOWN;
                end
            end
            ST_OPEN_OUT: begin
                if (pass_sensor) begin
                    if (occ_q != '0) begin
                        occ_d = occ_q - ONE_CNT;
                    end
                    state_d = ST_COOLDOWN;
                end else if (timer_expire) begin
                    state_d = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        auth_start_d    = (state_d == ST_AUTH) && (state_q != ST_AUTH);
        entrance_gate_d = (state_d == ST_OPEN_IN);
        exit_gate_d     = (state_d == ST_OPEN_OUT);
        busy_d          = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            last_served_q   <= LANE_ENTRY;
            occ_q           <= '0;
            auth_start_q    <= 1'b0;
            entrance_gate_q <= 1'b0;
            exit_gate_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_served_q   <= last_served_d;
            occ_q           <= occ_d;
            auth_start_q    <= auth_start_d;
            entrance_gate_q <= entrance_gate_d;
            exit_gate_q     <= exit_gate_d;
            busy_q          <= busy_d;
        end
    end

    assign auth_start    = auth_start_q;
    assign entrance_gate = entrance_gate_q;
    assign exit_gate     = exit_gate_q;
    assign occupancy     = occ_q;
    assign busy          = busy_q;

endmodule
